stream_mux_nx1: RTL and testbench
=================================

Name: stream_mux_nx1

Overview:
- Parametrised N-input, WIDTH-bit registered stream multiplexer; the successor to the team's single-bit 2:1 mux.
- Selects one of N valid/ready input channels and registers the chosen word into a one-entry output stage.
- Two selection modes:
  - explicit select, driven by an external sel input;
  - round-robin arbitration, for sharing a downstream consumer among N producers.

Parameters:
- N, 4, number of input channels (2..16).
- WIDTH, 8, data width per channel in bits (1..64).
- SEL_W, $clog2(N), width of sel and out_chan. Derived localparam; not overridable.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready. Combinational, at most one bit high.
- mode  input  1  0 = explicit select via sel; 1 = round-robin.
- sel  input  SEL_W  channel index, used only when mode=0.
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts when high with out_valid.
- out_chan  output  SEL_W  index of the channel that out_data came from.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled only on the rising edge of clk.
- Values while rst is high at an edge:
  - out_valid=0, out_data=0, out_chan=0;
  - round-robin last-grant pointer = N-1, so channel 0 has first priority.
- in_ready during reset: in_ready = 0 in any cycle where rst is high.
- load_en = !out_valid || out_ready. The output register can take a new word when it is empty, or when it is draining in the same cycle.
- Grant, computed combinationally each cycle:
  - mode=0: grant = channel sel if sel < N and in_valid[sel]; otherwise no grant. sel >= N (possible when N is not a power of 2) never grants.
  - mode=1: first channel with in_valid set, scanning (last+1) mod N upward with wrap-around to channel 0.
- in_ready[i] = load_en && grant==i && !rst. An input transfer occurs on channel i when in_valid[i] && in_ready[i].
- On an input transfer:
  - out_data <= that channel's word, out_chan <= i, out_valid <= 1;
  - mode=1 only: last <= i.
- If out_ready && out_valid and there is no input transfer: out_valid <= 0. out_data and out_chan keep their last values.
- Simultaneous drain and load in the same cycle: the new word replaces the old one. Full throughput is 1 word/cycle with no bubble.
- Backpressure: while out_valid && !out_ready, out_data and out_chan are held stable and all in_ready are 0.
- Latency: a word accepted at edge k is visible on out_data at edge k (registered output), i.e. one cycle from in_valid to out_valid.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, grants cycle 0,1,...,N-1,0,... A channel waits at most N-1 transfers.
- Idle cycles and mode=0 transfers do not move the pointer.
- mode and sel changes take effect in the same cycle they are applied. The protocol assumes they do not change while a stalled input is waiting; no internal locking is done.
- Upstream in_valid may drop without a transfer. The grant simply re-evaluates.
- Reset mid-operation: a word pending in the output register is discarded (out_valid=0 next cycle). The pointer returns to N-1.

Test Plan:
- Reset check: assert rst for 2 cycles with all in_valid=1 -> in_ready=0 during reset; after reset out_valid=0, out_data=0, out_chan=0.
- Explicit select, N=4, WIDTH=8, mode=0, out_ready=1: data ch0..3 = 8'h11, 8'h22, 8'h33, 8'h44, all valid, sel stepping 3,1,0 -> out_data 8'h44, 8'h22, 8'h11 on consecutive cycles with out_chan 3,1,0.
- Round-robin: mode=1, all four channels valid, out_ready=1 for 8 cycles -> out_chan sequence 0,1,2,3,0,1,2,3. Then only ch2 valid -> out_chan 2 every cycle.
- Backpressure: a word is loaded, then out_ready=0 for 3 cycles -> out_data/out_chan stable, in_ready=0. Raise out_ready with ch1 valid -> drain and load in the same cycle, no bubble.
- Out-of-range select: N=3, mode=0, sel=3, all valid -> no in_ready, out_valid stays 0.
- Mid-operation reset: out_valid=1 held by out_ready=0, pulse rst -> out_valid=0 next cycle. Next round-robin grant with all channels valid goes to ch0.

Source files
------------

// File: rtl/stream_mux_nx1_if.sv
// Stream mux port bundle: N input channels, one registered output.
// master drives the inputs, slave is the mux itself.
interface stream_mux_nx1_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  localparam int SEL_W = $clog2(N);

  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic               mode;
  logic [SEL_W-1:0]   sel;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic [SEL_W-1:0]   out_chan;

  modport master (
    output in_data,
    output in_valid,
    output mode,
    output sel,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_valid,
    input  out_chan
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  mode,
    input  sel,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_valid,
    output out_chan
  );
endinterface

// File: rtl/stream_mux_nx1.sv
// N-input registered stream mux with explicit-select and
// round-robin modes, one-entry output register.
module stream_mux_nx1 #(
  parameter int N     = 4,
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  stream_mux_nx1_if.slave s
);
  localparam int SEL_W = $clog2(N);

  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic [SEL_W-1:0] chan_q;
  logic [SEL_W-1:0] last_q;

  logic             load_en;
  logic             grant_vld;
  logic [SEL_W-1:0] grant_idx;
  logic [SEL_W-1:0] rr_idx;
  logic [WIDTH-1:0] word;
  logic             xfer;

  assign load_en = !valid_q || s.out_ready;
  assign xfer    = load_en && grant_vld && !rst;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    rr_idx    = '0;
    unique case (s.mode)
      1'b0: begin
        for (int i = 0; i < N; i++) begin
          if (s.sel == SEL_W'(i) && s.in_valid[i]) begin
            grant_vld = 1'b1;
            grant_idx = SEL_W'(i);
          end
        end
      end
      1'b1: begin
        // scan upward from the channel after the last grant
        for (int k = 1; k <= N; k++) begin
          rr_idx = SEL_W'((int'(last_q) + k) % N);
          if (!grant_vld && s.in_valid[rr_idx]) begin
            grant_vld = 1'b1;
            grant_idx = rr_idx;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    word = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == SEL_W'(i)) begin
        word = s.in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    s.in_ready = '0;
    for (int i = 0; i < N; i++) begin
      s.in_ready[i] = xfer && (grant_idx == SEL_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      chan_q  <= '0;
      last_q  <= SEL_W'(N - 1);
    end else if (xfer) begin
      data_q  <= word;
      valid_q <= 1'b1;
      chan_q  <= grant_idx;
      if (s.mode) begin
        last_q <= grant_idx;
      end
    end else if (s.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign s.out_data  = data_q;
  assign s.out_valid = valid_q;
  assign s.out_chan  = chan_q;
endmodule

// File: tb/tb_stream_mux_nx1.sv
// Self-checking bench for stream_mux_nx1: directed steps plus
// random traffic against a behavioural reference model.
module tb_stream_mux_nx1;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int N3 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  stream_mux_nx1_if #(.N(N), .WIDTH(W)) bus ();
  stream_mux_nx1_if #(.N(N3), .WIDTH(W)) bus3 ();

  stream_mux_nx1 #(.N(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus.slave)
  );

  stream_mux_nx1 #(.N(N3), .WIDTH(W)) dut3 (
    .clk (clk),
    .rst (rst),
    .s   (bus3.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // reference model state
  logic       m_valid;
  logic [7:0] m_data;
  int         m_chan;
  int         m_last;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant();
    int g;
    g = -1;
    if (!bus.mode) begin
      if (int'(bus.sel) < N && bus.in_valid[bus.sel]) g = int'(bus.sel);
    end else begin
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (g < 0 && bus.in_valid[c]) g = c;
      end
    end
    return g;
  endfunction

  // one clock: check in_ready, advance model, check outputs
  task automatic cyc();
    int         g;
    logic       ld;
    logic [3:0] exp_rdy;
    logic [31:0] d;
    #1;
    g  = model_grant();
    ld = !m_valid || bus.out_ready;
    exp_rdy = '0;
    if (!rst && ld && g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
    d = bus.in_data;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_chan  = 0;
      m_last  = N - 1;
    end else if (ld && g >= 0) begin
      m_valid = 1'b1;
      m_data  = d[g*W +: W];
      m_chan  = g;
      if (bus.mode) m_last = g;
    end else if (bus.out_ready) begin
      m_valid = 1'b0;
    end
    #1;
    chk("out_valid", 64'(bus.out_valid), 64'(m_valid));
    chk("out_data", 64'(bus.out_data), 64'(m_data));
    chk("out_chan", 64'(bus.out_chan), 64'(m_chan));
    @(negedge clk);
  endtask

  logic [7:0] held;

  initial begin
    m_valid = 1'b0;
    m_data  = '0;
    m_chan  = 0;
    m_last  = N - 1;
    bus.in_data   = 32'h44332211;
    bus.in_valid  = 4'hF;
    bus.mode      = 1'b1;
    bus.sel       = '0;
    bus.out_ready = 1'b1;
    bus3.in_data   = 24'hC3B2A1;
    bus3.in_valid  = '0;
    bus3.mode      = 1'b0;
    bus3.sel       = '0;
    bus3.out_ready = 1'b1;
    @(negedge clk);

    // reset with every channel valid
    rst = 1'b1;
    repeat (2) begin
      #1;
      chk("rst_in_ready", 64'(bus.in_ready), 64'h0);
      cyc();
    end
    chk("rst_out_valid", 64'(bus.out_valid), 64'h0);
    chk("rst_out_data", 64'(bus.out_data), 64'h0);
    chk("rst_out_chan", 64'(bus.out_chan), 64'h0);
    rst = 1'b0;

    // explicit select 3,1,0
    bus.mode = 1'b0;
    bus.sel = 2'd3; cyc();
    chk("sel3_data", 64'(bus.out_data), 64'h44);
    chk("sel3_chan", 64'(bus.out_chan), 64'd3);
    bus.sel = 2'd1; cyc();
    chk("sel1_data", 64'(bus.out_data), 64'h22);
    chk("sel1_chan", 64'(bus.out_chan), 64'd1);
    bus.sel = 2'd0; cyc();
    chk("sel0_data", 64'(bus.out_data), 64'h11);
    chk("sel0_chan", 64'(bus.out_chan), 64'd0);

    // round-robin with all valid, pointer untouched by mode 0
    bus.mode = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("rr_chan", 64'(bus.out_chan), 64'(i % N));
      chk("rr_valid", 64'(bus.out_valid), 64'h1);
    end
    bus.in_valid = 4'b0100;
    repeat (3) begin
      cyc();
      chk("rr_only2", 64'(bus.out_chan), 64'd2);
    end

    // backpressure for 3 cycles
    bus.in_valid = 4'hF;
    bus.out_ready = 1'b0;
    held = bus.out_data;
    repeat (3) begin
      #1;
      chk("bp_in_ready", 64'(bus.in_ready), 64'h0);
      cyc();
      chk("bp_data", 64'(bus.out_data), 64'(held));
      chk("bp_chan", 64'(bus.out_chan), 64'd2);
      chk("bp_valid", 64'(bus.out_valid), 64'h1);
    end
    bus.out_ready = 1'b1;
    bus.in_valid = 4'b0010;
    cyc();
    chk("bp_reload_valid", 64'(bus.out_valid), 64'h1);
    chk("bp_reload_chan", 64'(bus.out_chan), 64'd1);
    chk("bp_reload_data", 64'(bus.out_data), 64'h22);

    // reset while a word is held
    bus.out_ready = 1'b0;
    bus.in_valid = 4'hF;
    cyc();
    chk("mr_held", 64'(bus.out_valid), 64'h1);
    rst = 1'b1;
    cyc();
    chk("mr_cleared", 64'(bus.out_valid), 64'h0);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    chk("mr_first_ch0", 64'(bus.out_chan), 64'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      bus.in_data   = $urandom();
      bus.in_valid  = 4'($urandom());
      bus.mode      = ($urandom_range(0, 3) != 0);
      bus.sel       = 2'($urandom());
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst           = ($urandom_range(0, 49) == 0);
      cyc();
    end
    rst = 1'b0;

    // N=3 instance: out-of-range select never grants
    bus3.mode = 1'b0;
    bus3.sel = 2'd3;
    bus3.in_valid = 3'b111;
    repeat (3) begin
      #1;
      chk("n3_oor_ready", 64'(bus3.in_ready), 64'h0);
      @(posedge clk);
      #1;
      chk("n3_oor_valid", 64'(bus3.out_valid), 64'h0);
      @(negedge clk);
    end
    bus3.sel = 2'd2;
    #1;
    chk("n3_sel2_ready", 64'(bus3.in_ready), 64'h4);
    @(posedge clk);
    #1;
    chk("n3_sel2_valid", 64'(bus3.out_valid), 64'h1);
    chk("n3_sel2_data", 64'(bus3.out_data), 64'hC3);
    chk("n3_sel2_chan", 64'(bus3.out_chan), 64'd2);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
